// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares the single-port, synchronous-read program memory between the fetch
// stage and a loader/debug port. Fetch owns PMEM by default. The loader gets bursts of at
// most MAX_HOLD consecutive accesses, and each burst is followed by one forced fetch cycle.
// Fetch is stalled for the cycle after every cycle in which the loader owned PMEM, so that
// fetch replays its held instruction.
//
// Ports:
//   clock, reset    rising-edge clock; asynchronous active-high reset
//   in_fe_addr      fetch address            out_fe_instr   instruction to fetch
//   out_fe_stall    registered stall to fetch
//   in_ld_req/we    loader request / write   in_ld_addr     loader address
//   in_ld_wdata     loader write data        out_ld_gnt     access accepted (combinational)
//   out_ld_rvalid   registered read valid    out_ld_rdata   loader read data
//   out_mem_addr/we/wdata  PMEM request      in_mem_rdata   PMEM read data (1-cycle latency)
module pmem_arbiter #(
  parameter int unsigned PC_WIDTH   = 12,
  parameter int unsigned PMEM_WIDTH = 16,
  parameter int unsigned MAX_HOLD   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PC_WIDTH-1:0]   in_fe_addr,
  output logic [PMEM_WIDTH-1:0] out_fe_instr,
  output logic                  out_fe_stall,
  input  logic                  in_ld_req,
  input  logic                  in_ld_we,
  input  logic [PC_WIDTH-1:0]   in_ld_addr,
  input  logic [PMEM_WIDTH-1:0] in_ld_wdata,
  output logic                  out_ld_gnt,
  output logic                  out_ld_rvalid,
  output logic [PMEM_WIDTH-1:0] out_ld_rdata,
  output logic [PC_WIDTH-1:0]   out_mem_addr,
  output logic                  out_mem_we,
  output logic [PMEM_WIDTH-1:0] out_mem_wdata,
  input  logic [PMEM_WIDTH-1:0] in_mem_rdata
);

  // hold_cnt only has to reach MAX_HOLD-1
  localparam int unsigned CntW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    StFe,
    StLd,
    StYld
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
  logic            stall_q, stall_d;
  logic            rvalid_q, rvalid_d;

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    out_mem_addr  = in_fe_addr;
    out_mem_we    = 1'b0;
    // Write data is only qualified by out_mem_we, so it can follow the loader unconditionally
    out_mem_wdata = in_ld_wdata;
    out_ld_gnt    = 1'b0;

    unique case (state_q)
      StFe: begin
        if (in_ld_req) begin
          state_d = StLd;
        end
      end
      StLd: begin
        if (in_ld_req) begin
          out_ld_gnt   = 1'b1;
          out_mem_addr = in_ld_addr;
          out_mem_we   = in_ld_we;
          if (hold_cnt_q == HoldLast) begin
            // Burst exhausted: hand one cycle back to fetch
            state_d    = StYld;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + CntW'(1);
          end
        end else begin
          state_d    = StFe;
          hold_cnt_d = '0;
        end
      end
      StYld: begin
        hold_cnt_d = '0;
        state_d    = in_ld_req ? StLd : StFe;
      end
      default: begin
        state_d    = StFe;
        hold_cnt_d = '0;
      end
    endcase

    // Fetch must replay whatever it saw while the loader held the memory
    stall_d  = out_ld_gnt;
    rvalid_d = out_ld_gnt & ~in_ld_we;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StFe;
      hold_cnt_q <= '0;
      stall_q    <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      stall_q    <= stall_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign out_fe_stall  = stall_q;
  assign out_ld_rvalid = rvalid_q;
  assign out_fe_instr  = in_mem_rdata;
  assign out_ld_rdata  = in_mem_rdata;

endmodule
